preamble_inserter: RTL and testbench
====================================

Name: preamble_inserter

Overview:
- Transmit-side counterpart of the 802.11 short-preamble plateau detector: prepends a programmable periodic training sequence to every outgoing sample burst.
- Sits between the TX baseband sample source and the DAC-side sample stream on an AXI-stream interface.
- Per burst, emits PREAMBLE_LEN table samples, then the payload passthrough, then TAIL_LEN zero samples.
- The 16-entry table is loaded by a simple write port while the block is idle.

Parameters:
- PERIOD_LEN, 16: preamble period in samples; power of 2, 1..16.
- PREAMBLE_LEN, 160: total preamble samples per burst; >=1.
- TAIL_LEN, 16: zero samples appended after the payload; 0 allowed.
- WIDTH, 32: sample width, {I[15:0],Q[15:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  4  table index
- cfg_data  in  WIDTH  table entry
- i_tdata  in  WIDTH  payload sample
- i_tlast  in  1  last payload sample of burst
- i_tvalid  in  1  payload valid
- i_tready  out  1  payload accepted
- o_tdata  out  WIDTH  output sample
- o_tlast  out  1  last sample of burst
- o_tvalid  out  1  output valid
- o_tready  in  1  downstream ready
- busy  out  1  high in any state other than S_IDLE

Behaviour:
- Reset (async, any cycle, including mid-burst):
  - Immediately: state=S_IDLE, count=0, o_tvalid=0, o_tdata=0, o_tlast=0, busy=0, all 16 table entries=0.
  - Any burst in progress is abandoned; no partial output follows.
- Output stage: a single register.
  - load = ~o_tvalid | o_tready.
  - o_tdata/o_tlast/o_tvalid change only when load=1.
  - Sustains 1 sample/clk when o_tready is held high.
- States and transitions:
  - S_IDLE:
    - o_tvalid clears on load; i_tready=0.
    - When i_tvalid=1 and load=1: emit table[0], count<=1, go to S_PREAMBLE. The payload sample is not consumed.
    - Latency: first preamble sample valid on o_tdata 1 clk after i_tvalid is seen.
  - S_PREAMBLE:
    - i_tready=0.
    - On load: emit table[count mod PERIOD_LEN], count++.
    - When the sample with index PREAMBLE_LEN-1 is emitted, go to S_PAYLOAD and clear count.
    - If PREAMBLE_LEN=1, go from S_IDLE directly to S_PAYLOAD.
  - S_PAYLOAD:
    - i_tready = load; o_tvalid <= i_tvalid on load.
    - o_tdata <= i_tdata on handshake.
    - o_tlast <= i_tlast when TAIL_LEN=0, else 0.
    - On handshake with i_tlast=1: go to S_TAIL if TAIL_LEN>0, else S_IDLE.
    - An i_tvalid gap inserts a bubble (o_tvalid=0); it is not an error.
  - S_TAIL:
    - i_tready=0.
    - On load: emit 0, count++.
    - o_tlast=1 on sample TAIL_LEN-1; then go to S_IDLE, count=0.
- Back-to-back bursts: the next burst's preamble starts the cycle after the final output register load. No idle sample is required between bursts.
- Config writes:
  - cfg_we takes effect only in S_IDLE (table[cfg_addr]<=cfg_data).
  - Writes in other states are dropped.
  - A write coinciding with the S_IDLE->S_PREAMBLE transition is accepted. table[0] is read from the pre-write value.
- cfg_addr >= PERIOD_LEN: written, but never read.
- count width: clog2(max(PREAMBLE_LEN,TAIL_LEN)+1).
- No sample is ever dropped or duplicated under arbitrary o_tready/i_tvalid patterns.
- Exactly one o_tlast per burst.

Test Plan:
- Load table[k]=0x0000_000k (k=0..15); send 4 payload samples 0xA0..0xA3 (last on 0xA3), o_tready=1.
  - 180 samples out: 0..15 repeated 10 times, then A0..A3, then 16 zeros.
  - o_tlast only on sample 179; first output 1 clk after i_tvalid.
- Same stimulus with o_tready toggling 1,0,1,0 and random i_tvalid gaps.
  - Identical 180-sample sequence; i_tready=0 during preamble and tail.
  - o_tdata held stable while o_tvalid=1 and o_tready=0.
- Two 1-sample bursts back-to-back (0xB0 last, 0xB1 last), o_tready=1.
  - 354 contiguous valid samples; second preamble begins immediately after the first burst's tlast.
- cfg_we with table[0]=0xFFFF_FFFF issued during S_PREAMBLE.
  - Current and next burst still emit 0x0000_0000 at index 0.
  - Same write issued in S_IDLE: next burst emits 0xFFFF_FFFF at indices 0,16,...,144.
- Assert reset asynchronously at preamble sample 50.
  - o_tvalid=0 and busy=0 without a clock edge; table reads 0.
  - After reload and a new burst, the preamble restarts at index 0.
- TAIL_LEN=0, PREAMBLE_LEN=1 build, 3-sample payload.
  - Output is table[0],P0,P1,P2 with o_tlast on P2.

Source files
------------

// File: rtl/preamble_inserter.sv
// rtl/preamble_inserter.sv - prepends a periodic training preamble and zero tail to each TX sample burst
module preamble_inserter #(
    parameter int PERIOD_LEN   = 16,
    parameter int PREAMBLE_LEN = 160,
    parameter int TAIL_LEN     = 16,
    parameter int WIDTH        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             busy
);

    localparam int CNT_MAX = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'((TAIL_LEN == 0) ? 0 : TAIL_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_PAYLOAD,
        S_TAIL
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    count, count_d;
    logic [WIDTH-1:0] tbl [16];
    logic [WIDTH-1:0] tdata_d;
    logic             tlast_d;
    logic             tvalid_d;
    logic             load;
    logic [3:0]       tbl_idx;

    // The output register may only advance when empty or being drained
    assign load    = ~o_tvalid | o_tready;
    assign busy    = (state != S_IDLE);
    assign tbl_idx = 4'(count) & 4'(PERIOD_LEN - 1);

    always_comb begin
        state_d  = state;
        count_d  = count;
        tdata_d  = o_tdata;
        tlast_d  = o_tlast;
        tvalid_d = o_tvalid;
        i_tready = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    // The payload sample only triggers the preamble; it is consumed later
                    if (i_tvalid) begin
                        tvalid_d = 1'b1;
                        tdata_d  = tbl[0];
                        if (PREAMBLE_LEN == 1) begin
                            state_d = S_PAYLOAD;
                            count_d = '0;
                        end else begin
                            state_d = S_PREAMBLE;
                            count_d = CW'(1);
                        end
                    end
                end
            end
            S_PREAMBLE: begin
                if (load) begin
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = tbl[tbl_idx];
                    if (count == PRE_LAST) begin
                        state_d = S_PAYLOAD;
                        count_d = '0;
                    end else begin
                        count_d = count + CW'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                i_tready = load;
                if (load) begin
                    tvalid_d = i_tvalid;
                    tlast_d  = 1'b0;
                    if (i_tvalid) begin
                        tdata_d = i_tdata;
                        tlast_d = (TAIL_LEN == 0) ? i_tlast : 1'b0;
                        if (i_tlast) begin
                            state_d = (TAIL_LEN > 0) ? S_TAIL : S_IDLE;
                            count_d = '0;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (load) begin
                    tvalid_d = 1'b1;
                    tdata_d  = '0;
                    tlast_d  = (count == TAIL_LAST);
                    if (count == TAIL_LAST) begin
                        state_d = S_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
        end else begin
            state    <= state_d;
            count    <= count_d;
            o_tdata  <= tdata_d;
            o_tlast  <= tlast_d;
            o_tvalid <= tvalid_d;
        end
    end

    // Table is frozen while a burst is in flight so a burst never mixes two tables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we && (state == S_IDLE)) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_preamble_inserter.sv
// tb/tb_preamble_inserter.sv - directed self-checking bench for preamble_inserter
module tb_preamble_inserter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [31:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid;
    logic        o_tready = 1'b1;
    logic        busy;

    logic        d1_cfg_we;
    logic [3:0]  d1_cfg_addr;
    logic [31:0] d1_cfg_data;
    logic [31:0] d1_i_tdata;
    logic        d1_i_tlast, d1_i_tvalid, d1_i_tready;
    logic [31:0] d1_o_tdata;
    logic        d1_o_tlast, d1_o_tvalid;
    logic        d1_o_tready = 1'b1;
    logic        d1_busy;

    always #5 clk = ~clk;

    preamble_inserter dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .busy(busy)
    );

    preamble_inserter #(.PERIOD_LEN(16), .PREAMBLE_LEN(1), .TAIL_LEN(0), .WIDTH(32)) dut1 (
        .clk(clk), .reset(reset), .cfg_we(d1_cfg_we), .cfg_addr(d1_cfg_addr), .cfg_data(d1_cfg_data),
        .i_tdata(d1_i_tdata), .i_tlast(d1_i_tlast), .i_tvalid(d1_i_tvalid), .i_tready(d1_i_tready),
        .o_tdata(d1_o_tdata), .o_tlast(d1_o_tlast), .o_tvalid(d1_o_tvalid), .o_tready(d1_o_tready),
        .busy(d1_busy)
    );

    typedef struct {
        bit          rdy_tog;
        bit          gaps;
        int          npay;
        logic [31:0] base;
        int          exp_len;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat = -1;
    bit          rdy_toggle = 1'b0;
    logic [31:0] tblm [16];

    logic [32:0] got [$];
    int          burst_n = 0;
    int          rdy_err = 0;
    int          stab_err = 0;
    int          rise_cyc = 0;
    int          acc_cyc = 0;
    bit          in_tail = 1'b0;
    bit          stalled = 1'b0;
    bit          prev_v = 1'b0;
    logic [31:0] stall_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        o_tready = rdy_toggle ? ~o_tready : 1'b1;
    end

    // Collects accepted samples and watches handshake rules on the main instance
    always @(negedge clk) begin
        if (reset) begin
            burst_n = 0;
            in_tail = 1'b0;
            stalled = 1'b0;
            prev_v  = 1'b0;
        end else begin
            if (stalled && (!o_tvalid || o_tdata !== stall_data)) stab_err++;
            if (burst_n < 159 && i_tready) rdy_err++;
            if (in_tail && i_tready) rdy_err++;
            if (o_tvalid && !prev_v) rise_cyc = cyc;
            if (i_tvalid && i_tready && i_tlast) in_tail = 1'b1;
            if (o_tvalid && o_tready) begin
                got.push_back({o_tlast, o_tdata});
                acc_cyc = cyc;
                burst_n++;
                if (o_tlast) begin
                    burst_n = 0;
                    in_tail = 1'b0;
                end
            end
            stalled    = o_tvalid && !o_tready;
            stall_data = o_tdata;
            prev_v     = o_tvalid;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic load_table();
        for (int k = 0; k < 16; k++) begin
            cfg_write(4'(k), 32'(k));
            tblm[k] = 32'(k);
        end
    endtask

    task automatic send_burst(input logic [31:0] base, input int n, input bit gaps,
                              input bit co_we, input logic [31:0] co_data);
        int k;
        int budget;
        int iv_cyc;
        bit hs;
        k = 0;
        budget = 0;
        iv_cyc = -1;
        lat = -1;
        while (k < n && budget < 4000) begin
            i_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_tdata  = base + 32'(k);
            i_tlast  = (k == n - 1);
            if (iv_cyc < 0 && i_tvalid) begin
                iv_cyc = cyc;
                if (co_we) begin
                    cfg_we   = 1'b1;
                    cfg_addr = 4'd0;
                    cfg_data = co_data;
                end
            end
            @(negedge clk);
            hs = i_tvalid && i_tready;
            if (lat < 0 && iv_cyc >= 0 && o_tvalid) lat = cyc - iv_cyc;
            @(posedge clk); #1;
            if (co_we) cfg_we = 1'b0;
            if (hs) k++;
            budget++;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        if (k < n) check("send_timeout", 64'(k), 64'(n));
    endtask

    task automatic wait_out(input int target);
        int b;
        b = 0;
        while (got.size() < target && b < 3000) begin
            @(posedge clk); #1;
            b++;
        end
        if (got.size() < target) check("out_timeout", 64'(got.size()), 64'(target));
        repeat (5) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cmp_burst(input string nm, input int start, input logic [31:0] base,
                             input int n, input logic [31:0] first0);
        int          total;
        int          errs;
        logic [32:0] e;
        total = 176 + n;
        errs  = 0;
        for (int i = 0; i < total; i++) begin
            if (i == 0)            e = {1'b0, first0};
            else if (i < 160)      e = {1'b0, tblm[i % 16]};
            else if (i < 160 + n)  e = {1'b0, base + 32'(i - 160)};
            else                   e = {(i == total - 1), 32'h0};
            if (start + i >= got.size()) errs++;
            else if (got[start + i] !== e) errs++;
        end
        check({nm, "_bad_samples"}, 64'(errs), 64'd0);
    endtask

    initial begin
        vec_t        vecs [3];
        int          start;
        int          b;
        int          snap_r;
        int          snap_s;
        int          k;
        bit          hs;
        logic [32:0] q1 [$];
        logic [32:0] exp1 [4];

        reset = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        d1_cfg_we = 1'b0; d1_cfg_addr = '0; d1_cfg_data = '0;
        d1_i_tdata = '0; d1_i_tlast = 1'b0; d1_i_tvalid = 1'b0;
        for (int i = 0; i < 16; i++) tblm[i] = '0;

        vecs[0] = '{rdy_tog: 1'b0, gaps: 1'b0, npay: 4, base: 32'hA0, exp_len: 180};
        vecs[1] = '{rdy_tog: 1'b1, gaps: 1'b1, npay: 4, base: 32'hA0, exp_len: 180};
        vecs[2] = '{rdy_tog: 1'b1, gaps: 1'b1, npay: 7, base: 32'hD0, exp_len: 183};

        repeat (2) @(posedge clk);
        #1;
        check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_o_tdata", 64'(o_tdata), 64'd0);
        check("rst_o_tlast", 64'(o_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_i_tready", 64'(i_tready), 64'd0);
        check("rst_d1_busy", 64'(d1_busy), 64'd0);
        reset = 1'b0;

        load_table();

        for (int v = 0; v < 3; v++) begin
            rdy_toggle = vecs[v].rdy_tog;
            start  = got.size();
            snap_r = rdy_err;
            snap_s = stab_err;
            send_burst(vecs[v].base, vecs[v].npay, vecs[v].gaps, 1'b0, 32'h0);
            wait_out(start + vecs[v].exp_len);
            check($sformatf("v%0d_len", v), 64'(got.size() - start), 64'(vecs[v].exp_len));
            cmp_burst($sformatf("v%0d", v), start, vecs[v].base, vecs[v].npay, tblm[0]);
            check($sformatf("v%0d_latency", v), 64'(lat), 64'd1);
            check($sformatf("v%0d_i_tready_rule", v), 64'(rdy_err - snap_r), 64'd0);
            check($sformatf("v%0d_hold_stable", v), 64'(stab_err - snap_s), 64'd0);
        end

        rdy_toggle = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        start = got.size();
        send_burst(32'hB0, 1, 1'b0, 1'b0, 32'h0);
        send_burst(32'hB1, 1, 1'b0, 1'b0, 32'h0);
        wait_out(start + 354);
        check("b2b_len", 64'(got.size() - start), 64'd354);
        cmp_burst("b2b_first", start, 32'hB0, 1, tblm[0]);
        cmp_burst("b2b_second", start + 177, 32'hB1, 1, tblm[0]);
        check("b2b_contiguous", 64'(acc_cyc - rise_cyc), 64'd353);

        start = got.size();
        fork
            send_burst(32'hE0, 2, 1'b0, 1'b0, 32'h0);
            begin
                b = 0;
                while (got.size() < start + 20 && b < 500) begin
                    @(posedge clk); #1;
                    b++;
                end
                check("cfg_busy_in_preamble", 64'(busy), 64'd1);
                cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 32'hFFFF_FFFF;
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
        join
        wait_out(start + 178);
        cmp_burst("cfg_drop_cur", start, 32'hE0, 2, 32'h0);

        start = got.size();
        send_burst(32'hE8, 2, 1'b0, 1'b0, 32'h0);
        wait_out(start + 178);
        cmp_burst("cfg_drop_next", start, 32'hE8, 2, 32'h0);

        cfg_write(4'd0, 32'hFFFF_FFFF);
        tblm[0] = 32'hFFFF_FFFF;
        start = got.size();
        send_burst(32'hE4, 2, 1'b0, 1'b0, 32'h0);
        wait_out(start + 178);
        cmp_burst("cfg_idle", start, 32'hE4, 2, 32'hFFFF_FFFF);

        start = got.size();
        send_burst(32'hF0, 1, 1'b0, 1'b1, 32'h1234_5678);
        tblm[0] = 32'h1234_5678;
        wait_out(start + 177);
        cmp_burst("cfg_coincide", start, 32'hF0, 1, 32'hFFFF_FFFF);
        check("cfg_coincide_idx16", 64'(got[start + 16][31:0]), 64'h1234_5678);

        load_table();
        start = got.size();
        i_tvalid = 1'b1; i_tdata = 32'hC0; i_tlast = 1'b1;
        b = 0;
        while (got.size() < start + 50 && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("rst_reach_50", 64'(got.size() >= start + 50), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_o_tvalid", 64'(o_tvalid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_o_tdata", 64'(o_tdata), 64'd0);
        i_tvalid = 1'b0; i_tlast = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        start = got.size();
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("arst_no_partial", 64'(got.size() - start), 64'd0);

        for (int i = 0; i < 16; i++) tblm[i] = '0;
        start = got.size();
        send_burst(32'hA0, 4, 1'b0, 1'b0, 32'h0);
        wait_out(start + 180);
        cmp_burst("arst_table_zero", start, 32'hA0, 4, 32'h0);

        load_table();
        start = got.size();
        send_burst(32'hA0, 4, 1'b0, 1'b0, 32'h0);
        wait_out(start + 180);
        check("arst_restart_len", 64'(got.size() - start), 64'd180);
        cmp_burst("arst_restart", start, 32'hA0, 4, tblm[0]);

        d1_cfg_we = 1'b1; d1_cfg_addr = 4'd0; d1_cfg_data = 32'h55;
        @(posedge clk); #1;
        d1_cfg_we = 1'b0;
        exp1[0] = {1'b0, 32'h55};
        exp1[1] = {1'b0, 32'hC0};
        exp1[2] = {1'b0, 32'hC1};
        exp1[3] = {1'b1, 32'hC2};
        k = 0;
        for (int c = 0; c < 20 && q1.size() < 4; c++) begin
            d1_i_tvalid = (k < 3);
            d1_i_tdata  = 32'hC0 + 32'(k);
            d1_i_tlast  = (k == 2);
            @(negedge clk);
            hs = d1_i_tvalid && d1_i_tready;
            if (d1_o_tvalid && d1_o_tready) q1.push_back({d1_o_tlast, d1_o_tdata});
            @(posedge clk); #1;
            if (hs) k++;
        end
        d1_i_tvalid = 1'b0;
        d1_i_tlast  = 1'b0;
        check("d1_len", 64'(q1.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d1_sample%0d", i), 64'(q1[i]), 64'(exp1[i]));
        end
        check("d1_idle_after", 64'(d1_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
